// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the UART slice.
//   baud_state       : baud generator FSM state (idle / counting)
//   UART_DEFAULT_DIV : integer divisor active out of reset
package uart_pkg;

  typedef enum logic {
    BAUD_IDLE  = 1'b0,
    BAUD_COUNT = 1'b1
  } baud_state;

  localparam int UART_DEFAULT_DIV = 163;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- fractional baud-rate tick generator.
//
// Produces a one-cycle oversample pulse (tick) every div_act + frac_act/2^FRAC_W
// cycles on average, and bit_tick on every OVERSAMPLE-th tick. The fractional
// part is realised by stretching a period by one cycle whenever the phase
// accumulator overflows at the previous tick.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   enable       : generator runs while high
//   load         : one-cycle strobe capturing div_int_in / div_frac_in
//   div_int_in   : requested integer divisor (0 and 1 behave as 2)
//   div_frac_in  : requested fractional divisor, units of 1/2^FRAC_W cycle
//   resync       : restart the phase (RX start-bit alignment)
//   tick         : one-cycle oversample pulse
//   bit_tick     : one-cycle pulse on every OVERSAMPLE-th tick
//   dbg_state_o  : current FSM state, for observation only
//
// Handshake: load and resync are plain single-cycle strobes with no ready;
// a new divisor is parked in shadow registers and becomes active at the next
// tick (or at once while idle), so a running period is never cut short.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  input  logic              resync,
  output logic              tick,
  output logic              bit_tick,
  output baud_state         dbg_state_o
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] RST_DIV =
    (DEFAULT_DIV < 2) ? DIV_MIN : DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W:0]   ONE_P   = (DIV_W+1)'(1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  baud_state         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  div_act_q, div_act_d;
  logic [FRAC_W-1:0] frac_act_q, frac_act_d;
  logic [DIV_W-1:0]  shd_div_q, shd_div_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;

  // period is DIV_W+1 bits wide so div = 2^DIV_W-1 plus carry cannot overflow.
  logic [DIV_W:0]    period;
  logic              terminal;
  logic              fire;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W-1:0]  div_eff;
  logic [FRAC_W-1:0] frac_eff;

  always_comb begin
    period   = {1'b0, div_act_q} + {{DIV_W{1'b0}}, carry_q};
    terminal = (state_q == BAUD_COUNT) && ({1'b0, cnt_q} == (period - ONE_P));
    // resync and a falling enable both swallow the terminal-count pulse.
    fire     = terminal && enable && !resync;
    acc_sum  = {1'b0, acc_q} + {1'b0, frac_act_q};
    // A load coinciding with a tick goes straight through to the active set.
    div_eff  = load ? clamp_div(div_int_in) : shd_div_q;
    frac_eff = load ? div_frac_in : shd_frac_q;
  end

  assign tick        = rst_n && fire;
  assign bit_tick    = rst_n && fire && (os_q == OS_LAST);
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    os_d       = os_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    div_act_d  = div_act_q;
    frac_act_d = frac_act_q;
    shd_div_d  = div_eff;
    shd_frac_d = frac_eff;

    case (state_q)
      BAUD_IDLE: begin
        cnt_d      = '0;
        os_d       = '0;
        acc_d      = '0;
        carry_d    = 1'b0;
        div_act_d  = div_eff;
        frac_act_d = frac_eff;
        if (enable) state_d = BAUD_COUNT;
      end
      BAUD_COUNT: begin
        if (!enable || resync) begin
          // Leaving or restarting: the next period starts from a clean phase.
          cnt_d   = '0;
          os_d    = '0;
          acc_d   = '0;
          carry_d = 1'b0;
          if (!enable) state_d = BAUD_IDLE;
        end else if (fire) begin
          cnt_d      = '0;
          os_d       = (os_q == OS_LAST) ? '0 : os_q + OS_W'(1);
          acc_d      = acc_sum[FRAC_W-1:0];
          carry_d    = acc_sum[FRAC_W];
          div_act_d  = div_eff;
          frac_act_d = frac_eff;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = BAUD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BAUD_IDLE;
      cnt_q      <= '0;
      os_q       <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      div_act_q  <= RST_DIV;
      frac_act_q <= '0;
      shd_div_q  <= RST_DIV;
      shd_frac_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      os_q       <= os_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      div_act_q  <= div_act_d;
      frac_act_q <= frac_act_d;
      shd_div_q  <= shd_div_d;
      shd_frac_q <= shd_frac_d;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen -- directed, table-driven bench for uart_baud_gen.
// Inputs change 1-2 time units after a rising edge; outputs are sampled
// 2 time units after the edge, once the combinational tick has settled.
module tb_uart_baud_gen;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] div_int_in;
  logic [3:0]  div_frac_in;
  logic        resync;
  logic        tick;
  logic        bit_tick;
  baud_state   dbg_state;

  always #5 clk = ~clk;

  uart_baud_gen #(
    .DIV_W(16), .FRAC_W(4), .OVERSAMPLE(16), .DEFAULT_DIV(163)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .div_int_in(div_int_in), .div_frac_in(div_frac_in), .resync(resync),
    .tick(tick), .bit_tick(bit_tick), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  // Edges until the next tick; gap = -1 if none within max edges.
  task automatic next_tick(input int max, output int gap, output int bit_seen);
    gap = -1;
    bit_seen = 0;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #2;
      if (tick === 1'b1) begin
        gap = i;
        bit_seen = int'(bit_tick);
        return;
      end
    end
  endtask

  task automatic run_edges(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      @(posedge clk); #2;
      if (tick === 1'b1) ticks++;
    end
  endtask

  // Drop to idle, load a divisor there, then raise enable (state still idle).
  task automatic go_idle_load(input logic [15:0] d, input logic [3:0] f);
    enable = 1'b0;
    resync = 1'b0;
    @(posedge clk); #2;
    div_int_in  = d;
    div_frac_in = f;
    load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    enable = 1'b1;
  endtask

  // n ticks all spaced by period; bit_tick only on the n-th.
  task automatic check_train(input string name, input int period, input int n);
    int g, b, bad_gap, early, last_bit, first_gap;
    bad_gap = 0; early = 0; last_bit = 0; first_gap = 0;
    for (int k = 1; k <= n; k++) begin
      next_tick(period + 4, g, b);
      if (k == 1) first_gap = g;
      if (g != period) bad_gap++;
      if (k < n && b != 0) early++;
      if (k == n) last_bit = b;
    end
    check({name, "_first_gap"}, first_gap, period);
    check({name, "_bad_gaps"}, bad_gap, 0);
    check({name, "_early_bit"}, early, 0);
    check({name, "_last_bit"}, last_bit, 1);
  endtask

  // ---------------- vector table ----------------
  // Gap j after enable is base + extra[j]; extra marks periods stretched by
  // the fractional carry (hand-computed from the accumulator sequence).
  typedef struct packed {
    logic [15:0] div_in;
    logic [3:0]  frac_in;
    logic [7:0]  base;
    logic [5:0]  extra;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t, g, b;
    vecs[0] = '{div_in: 16'd10, frac_in: 4'd8,  base: 8'd10, extra: 6'b010100};
    vecs[1] = '{div_in: 16'd0,  frac_in: 4'd0,  base: 8'd2,  extra: 6'b000000};
    vecs[2] = '{div_in: 16'd1,  frac_in: 4'd0,  base: 8'd2,  extra: 6'b000000};
    vecs[3] = '{div_in: 16'd2,  frac_in: 4'd0,  base: 8'd2,  extra: 6'b000000};
    vecs[4] = '{div_in: 16'd5,  frac_in: 4'd4,  base: 8'd5,  extra: 6'b010000};
    vecs[5] = '{div_in: 16'd3,  frac_in: 4'd15, base: 8'd3,  extra: 6'b111100};
    vecs[6] = '{div_in: 16'd4,  frac_in: 4'd12, base: 8'd4,  extra: 6'b011100};

    rst_n = 1'b0; enable = 1'b1; load = 1'b0; resync = 1'b0;
    div_int_in = '0; div_frac_in = '0;

    // Reset held with enable high: nothing must come out.
    run_edges(3, t);
    check("reset_ticks", t, 0);
    check("reset_bit_tick", int'(bit_tick), 0);
    check("reset_state", int'(dbg_state), int'(BAUD_IDLE));

    // Release reset with enable=1: default divisor 163, bit_tick on 16th tick.
    rst_n = 1'b1;
    check_train("default163", 163, 16);

    // Reset mid-period discards the period; counting restarts from scratch.
    run_edges(50, t);
    check("pre_reset_ticks", t, 0);
    rst_n = 1'b0;
    run_edges(200, t);
    check("mid_reset_ticks", t, 0);
    rst_n = 1'b1;
    next_tick(170, g, b);
    check("post_reset_gap", g, 163);

    // Table: tick spacings for integer/fractional divisors incl. clamping.
    foreach (vecs[i]) begin
      go_idle_load(vecs[i].div_in, vecs[i].frac_in);
      for (int j = 0; j < 6; j++) begin
        next_tick(int'(vecs[i].base) + 4, g, b);
        check($sformatf("vec%0d_gap%0d", i, j), g,
              int'(vecs[i].base) + int'(vecs[i].extra[j]));
      end
    end

    // Load at cnt=5 of a 10-cycle period: current period keeps 10, next is 20.
    go_idle_load(16'd10, 4'd0);
    next_tick(14, g, b);
    check("load_mid_first", g, 10);
    run_edges(6, t);
    check("load_mid_quiet", t, 0);
    div_int_in = 16'd20;
    load = 1'b1;
    @(posedge clk); #2;
    load = 1'b0;
    next_tick(14, g, b);
    check("load_mid_cur_period", 6 + 1 + g, 10);
    next_tick(24, g, b);
    check("load_mid_next_period", g, 20);
    next_tick(24, g, b);
    check("load_mid_after", g, 20);

    // Resync at cnt=7: no tick at old terminal, next tick 10 after resync,
    // bit_tick on the 16th tick after resync.
    go_idle_load(16'd10, 4'd0);
    next_tick(14, g, b);
    check("resync_first", g, 10);
    run_edges(8, t);
    check("resync_quiet", t, 0);
    resync = 1'b1;
    #1;
    check("resync_cycle_tick", int'(tick), 0);
    @(posedge clk); #1;
    resync = 1'b0;
    #1;
    next_tick(14, g, b);
    check("resync_gap", 1 + g, 10);
    check("resync_gap_bit", b, 0);
    check_train("post_resync", 10, 15);

    // Resync exactly on the terminal count wins over the tick.
    run_edges(9, t);
    check("resync_tc_quiet", t, 0);
    @(posedge clk); #1;
    resync = 1'b1;
    #1;
    check("resync_tc_tick", int'(tick), 0);
    check("resync_tc_bit", int'(bit_tick), 0);
    @(posedge clk); #1;
    resync = 1'b0;
    #1;
    next_tick(14, g, b);
    check("resync_tc_gap", 1 + g, 10);

    // Resync while idle is ignored: the next enable still counts a full period.
    enable = 1'b0;
    @(posedge clk); #2;
    resync = 1'b1;
    @(posedge clk); #2;
    check("idle_resync_state", int'(dbg_state), int'(BAUD_IDLE));
    resync = 1'b0;

    // Enable dropped at the terminal count: no tick; re-enable restarts cleanly.
    go_idle_load(16'd10, 4'd0);
    next_tick(14, g, b);
    check("en_drop_t1", g, 10);
    next_tick(14, g, b);
    check("en_drop_t2", g, 10);
    run_edges(9, t);
    check("en_drop_quiet", t, 0);
    @(posedge clk); #1;
    enable = 1'b0;
    #1;
    check("en_drop_tc_tick", int'(tick), 0);
    check("en_drop_tc_bit", int'(bit_tick), 0);
    @(posedge clk); #2;
    check("en_drop_state", int'(dbg_state), int'(BAUD_IDLE));
    enable = 1'b1;
    check_train("reenable", 10, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
